// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side decoder for a VGA-style hsync/vsync/rrggbb stream. Measures line
// and frame timing, locks when the timing matches the parameters, and then
// recovers active-window pixel coordinates. It also captures the colour at a
// programmable probe coordinate.
//
// Ports
//   clk          pixel clock, same domain as the video source
//   reset        asynchronous, active-high reset
//   hsync/vsync  sync inputs, active level SYNC_POL
//   rrggbb       pixel colour
//   probe_x/y    probe coordinate inside the active window
//   x/y          active column/row, 0 when active=0
//   active       locked and inside the active window
//   frame_start  one-cycle pulse per vsync leading edge
//   line_len     last measured line length in clocks (1023 = overflow)
//   frame_lines  last measured frame length in lines
//   locked       timing matches the parameters
//   probe_data   colour captured at (probe_x, probe_y)
//   probe_stb    one-cycle pulse when probe_data updates
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOCK_FRM = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [5:0] rrggbb,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic [5:0] probe_data,
  output logic       probe_stb
);

  localparam logic       ACT    = SYNC_POL[0];
  localparam logic [9:0] CMAX   = 10'h3FF;
  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] H_ST   = 10'(H_START);
  localparam logic [9:0] V_ST   = 10'(V_START);
  localparam logic [10:0] H_END = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_END = 11'(V_START + V_ACTIVE);
  localparam int         CW     = (LOCK_FRM < 2) ? 1 : $clog2(LOCK_FRM + 1);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRM);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] good_cnt, cnt_d, cnt_inc;

  logic       hs_r, vs_r, hs_p, vs_p;
  logic [5:0] rgb_r;
  logic [9:0] hcnt, vcnt;
  logic       ovf_h, ovf_v, frame_bad, probe_done;

  // Input register stage. Sync copies reset to the inactive level so that
  // leaving reset never fakes a leading edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r  <= ~ACT;
      vs_r  <= ~ACT;
      hs_p  <= ~ACT;
      vs_p  <= ~ACT;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      rgb_r <= rrggbb;
    end
  end

  logic       hedge, vedge;
  logic [9:0] hcnt_sat, vcnt_sat, vcnt_step, hpos, vpos, xpos, ypos;
  logic       good_line, bad_line, good_frm, ovf_v_now, in_win, hit;

  assign hedge = (hs_r == ACT) && (hs_p != ACT);
  assign vedge = (vs_r == ACT) && (vs_p != ACT);

  // hcnt lags the sample in rgb_r by one clock, so the saturating increment is
  // both the length of the line just ended and the column of rgb_r.
  assign hcnt_sat  = (hcnt == CMAX) ? hcnt : hcnt + 10'd1;
  assign vcnt_sat  = (vcnt == CMAX) ? vcnt : vcnt + 10'd1;
  assign vcnt_step = hedge ? vcnt_sat : vcnt;
  assign hpos      = hedge ? 10'd0 : hcnt_sat;
  // Coincident edges: the hsync edge closes the last line of the old frame,
  // then vsync restarts the count at 0 for the new frame.
  assign vpos      = vedge ? 10'd0 : vcnt_step;

  assign good_line = (hcnt_sat == H_TOT) && !ovf_h;
  assign bad_line  = hedge && !good_line;
  assign ovf_v_now = ovf_v || (hedge && (vcnt == CMAX));
  assign good_frm  = !frame_bad && !bad_line && (vcnt_step == V_TOT) && !ovf_v_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      ovf_h       <= 1'b0;
      ovf_v       <= 1'b0;
      frame_bad   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hpos;
      vcnt        <= vpos;
      ovf_h       <= !hedge && (ovf_h || (hcnt == CMAX));
      ovf_v       <= !vedge && ovf_v_now;
      frame_bad   <= !vedge && (frame_bad || bad_line);
      frame_start <= vedge;
      // 1024 does not fit in 10 bits; an overflowed line reads as 1023.
      if (hedge) line_len <= hcnt_sat;
      if (vedge) frame_lines <= vcnt_step;
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      good_cnt <= '0;
    end else begin
      state_q  <= state_d;
      good_cnt <= cnt_d;
    end
  end

  assign cnt_inc = good_cnt + 1'b1;

  // Lock FSM: next state.
  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = good_cnt;
    unique case (state_q)
      HUNT: begin
        if (vedge) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (vedge) begin
          if (good_frm) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_N) state_d = LOCKED;
          end else begin
            cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (bad_line || (vedge && !good_frm) || ovf_h) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Lock FSM: outputs.
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Coordinates of the sample in rgb_r; outputs register one clock later.
  assign xpos   = hpos - H_ST;
  assign ypos   = vpos - V_ST;
  assign in_win = locked &&
                  ({1'b0, hpos} >= {1'b0, H_ST}) && ({1'b0, hpos} < H_END) &&
                  ({1'b0, vpos} >= {1'b0, V_ST}) && ({1'b0, vpos} < V_END);
  assign hit    = in_win && (xpos == probe_x) && (ypos == probe_y) && !probe_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active     <= 1'b0;
      x          <= '0;
      y          <= '0;
      probe_data <= '0;
      probe_stb  <= 1'b0;
      probe_done <= 1'b0;
    end else begin
      active     <= in_win;
      x          <= in_win ? xpos : 10'd0;
      y          <= in_win ? ypos : 10'd0;
      probe_stb  <= hit;
      probe_done <= hit || (probe_done && !vedge);
      if (hit) probe_data <= rgb_r;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Scoreboard bench for vga_sync_decoder on a scaled-down timing (40 clocks per
// line, 20 lines per frame) with the same structure as 640x480: sync first,
// then back porch, active, front porch. The driver pushes expected probe
// strobes and frame_start events; monitors pop and compare on DUT pulses.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HST = 8;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VS  = 2;
  localparam int VST = 3;
  localparam int VA  = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync;
  logic [5:0] rrggbb;
  logic [9:0] probe_x, probe_y;
  logic [9:0] x, y, line_len, frame_lines;
  logic       active, frame_start, locked, probe_stb;
  logic [5:0] probe_data;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HST), .V_START(VST),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRM(2), .SYNC_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .probe_x(probe_x), .probe_y(probe_y), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .probe_data(probe_data), .probe_stb(probe_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] data;
    int         cyc;
    int         px;
    int         py;
  } probe_t;

  typedef struct {
    bit chk;
    int lines;
    int len;
    int cyc;
  } frame_t;

  probe_t probe_q[$];
  frame_t frame_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int line_cyc, vs_cyc;
  int lock_rise = -1, lock_fall = -1;
  int stb_count = 0;
  bit lock_prev = 1'b0;
  bit frame_known = 1'b0;
  bit expect_probe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] pix(input int col, input int row);
    if (col == HST && row == VST) return 6'h3F;
    if (col == HST + HA - 1 && row == VST + VA - 1) return 6'h15;
    return 6'h2A;
  endfunction

  // One line: hsync active for HS clocks at the start, vsync active on rows < VS.
  task automatic drive_line(input int row, input int len);
    for (int col = 0; col < len; col++) begin
      @(posedge clk); #1;
      hsync  = (col < HS) ? 1'b0 : 1'b1;
      vsync  = (row < VS) ? 1'b0 : 1'b1;
      rrggbb = pix(col, row);
      if (col == 0) begin
        line_cyc = cyc;
        if (row == 0) begin
          vs_cyc = cyc;
          frame_q.push_back('{frame_known, VT, HT, cyc + 2});
        end
      end
      if (expect_probe && probe_x < HA && probe_y < VA &&
          col == HST + int'(probe_x) && row == VST + int'(probe_y))
        probe_q.push_back('{pix(col, row), cyc + 2, int'(probe_x), int'(probe_y)});
    end
  endtask

  task automatic drive_frame();
    for (int r = 0; r < VT; r++) drive_line(r, HT);
    frame_known = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_probe_data"}, probe_data, 0);
    check({tag, "_probe_stb"}, probe_stb, 0);
  endtask

  // Lock transition watcher.
  always @(negedge clk) begin
    if (locked && !lock_prev) lock_rise = cyc;
    if (!locked && lock_prev) lock_fall = cyc;
    lock_prev = locked;
  end

  // Probe monitor.
  always @(negedge clk) begin
    if (!reset && probe_stb) begin
      probe_t e;
      stb_count++;
      if (probe_q.size() == 0) begin
        check("probe_unexpected", 1, 0);
      end else begin
        e = probe_q.pop_front();
        check("probe_data", probe_data, e.data);
        check("probe_cycle", cyc, e.cyc);
        check("probe_x_out", x, e.px);
        check("probe_y_out", y, e.py);
        check("probe_active", active, 1);
      end
    end
  end

  // Frame monitor.
  always @(negedge clk) begin
    if (!reset && frame_start) begin
      frame_t f;
      if (frame_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        f = frame_q.pop_front();
        check("frame_start_cycle", cyc, f.cyc);
        if (f.chk) begin
          check("frame_lines", frame_lines, f.lines);
          check("line_len", line_len, f.len);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    hsync   = 1'b1;
    vsync   = 1'b1;
    rrggbb  = '0;
    probe_x = 10'd0;
    probe_y = 10'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Stream starts mid-frame while reset is held; released mid-frame.
    for (int r = 10; r < 13; r++) drive_line(r, HT);
    reset = 1'b0;
    for (int r = 13; r < VT; r++) drive_line(r, HT);

    drive_frame();                 // vsync edge 1 -> CHECK
    drive_frame();                 // vsync edge 2 -> one good frame
    check("unlocked_before_3rd_vs", locked, 0);

    stb_count    = 0;
    expect_probe = 1'b1;
    drive_frame();                 // vsync edge 3 -> LOCKED
    check("lock_at_3rd_vs", lock_rise, vs_cyc + 2);
    drive_frame();
    check("stb_once_per_frame", stb_count, 2);

    probe_x = 10'(HA - 1);
    probe_y = 10'(VA - 1);
    drive_frame();

    probe_x   = 10'(HA);
    probe_y   = 10'd0;
    stb_count = 0;
    drive_frame();
    check("probe_outside_no_stb", stb_count, 0);

    // Short line while locked: row 7 lasts HT-1 clocks.
    expect_probe = 1'b0;
    for (int r = 0; r < VT; r++) begin
      drive_line(r, (r == 7) ? HT - 1 : HT);
      if (r == 8) check("lock_fall_short_line", lock_fall, line_cyc + 2);
    end
    check("unlocked_after_short", locked, 0);
    drive_frame();                 // vsync -> CHECK
    drive_frame();                 // one good frame
    check("unlocked_before_relock", locked, 0);
    probe_x      = 10'd0;
    probe_y      = 10'd0;
    expect_probe = 1'b1;
    stb_count    = 0;
    drive_frame();                 // relocks at this vsync edge
    check("relock_after_short", lock_rise, vs_cyc + 2);

    // hsync held inactive for 1100 clocks on row 16.
    for (int r = 0; r < VT; r++) begin
      drive_line(r, (r == 16) ? HS + 1100 : HT);
      if (r == 17) begin
        check("ovf_line_len", line_len, 1023);
        check("ovf_unlocked", locked, 0);
      end
    end
    check("stb_count_relock", stb_count, 2);
    expect_probe = 1'b0;
    drive_frame();
    drive_frame();

    // Partial line, then asynchronous reset between clock edges.
    drive_line(0, 20);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);

    check("probe_queue_empty", probe_q.size(), 0);
    check("frame_queue_empty", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
